// File: rtl/game_ctrl_fsm_param.sv
`default_nettype none
// ============================================================================
// Module : game_ctrl_fsm_param
// Brief  : Synchronises, debounces and edge-detects NUM_BTN push-buttons and
//          drives the IDLE/PLAY/PAUSE/OVER game state machine.
// Rev    : 1.0  initial release
// ============================================================================
module game_ctrl_fsm_param #(
  parameter int NUM_BTN     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16,
  parameter int OVER_HOLD   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] rawButton,
  input  logic               GO,
  output logic [NUM_BTN-1:0] btnLevel,
  output logic [NUM_BTN-1:0] btnPress,
  output logic [2:0]         outputState,
  output logic               playing
);

  localparam int                  c_DB_W      = $clog2(DB_CYCLES + 1);
  localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DB_CYCLES - 1);
  localparam int                  c_HOLD_W    = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = (OVER_HOLD > 0) ? c_HOLD_W'(OVER_HOLD - 1) : '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    PAUSE = 3'd2,
    OVER  = 3'd3
  } state_t;

  // State kept as a plain vector so the illegal codes 4..7 remain representable.
  logic [2:0]          r_state;
  logic [2:0]          w_next;
  logic [c_HOLD_W-1:0] r_hold;
  logic                w_hold_done;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic [SYNC_STAGES-1:0] r_sync;
      logic [c_DB_W-1:0]      r_cnt;
      logic                   r_lvl;
      logic                   r_press;
      logic                   w_s;

      assign w_s          = r_sync[SYNC_STAGES-1];
      assign btnLevel[gi] = r_lvl;
      assign btnPress[gi] = r_press;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_sync  <= '0;
          r_cnt   <= '0;
          r_lvl   <= 1'b0;
          r_press <= 1'b0;
        end else begin
          r_sync  <= {r_sync[SYNC_STAGES-2:0], rawButton[gi]};
          r_press <= 1'b0;
          if (w_s == r_lvl) begin
            r_cnt <= '0;
          end else if (r_cnt == c_DB_LAST) begin
            // Level accepted: a rising acceptance doubles as the press pulse.
            r_lvl   <= w_s;
            r_press <= w_s;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  endgenerate

  assign w_hold_done = (OVER_HOLD != 0) && (r_hold == c_HOLD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (btnPress[0]) w_next = PLAY;
      PLAY: begin
        if (GO)               w_next = OVER;
        else if (btnPress[1]) w_next = PAUSE;
      end
      PAUSE:   if (btnPress[0] || btnPress[1]) w_next = PLAY;
      OVER:    if (btnPress[0] || w_hold_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Counts cycles already spent in OVER; zero on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
    end else if (r_state == OVER && w_next == OVER) begin
      r_hold <= r_hold + 1'b1;
    end else begin
      r_hold <= '0;
    end
  end

  assign outputState = r_state;
  assign playing     = (r_state == PLAY);

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl_fsm_param.sv
`default_nettype none
// ============================================================================
// Module : tb_game_ctrl_fsm_param
// Brief  : Self-checking bench for game_ctrl_fsm_param (vectors, corner
//          sequences, randomized traffic against a window-based model).
// Rev    : 1.0  initial release
// ============================================================================
module tb_game_ctrl_fsm_param;

  localparam int NB = 4;
  localparam int SY = 2;
  localparam int DB = 4;
  localparam int OH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] rawButton;
  logic          GO;
  logic [NB-1:0] btnLevel;
  logic [NB-1:0] btnPress;
  logic [2:0]    outputState;
  logic          playing;

  int checks = 0;
  int errors = 0;

  game_ctrl_fsm_param #(
    .NUM_BTN(NB), .SYNC_STAGES(SY), .DB_CYCLES(DB), .OVER_HOLD(OH)
  ) dut (
    .clk(clk), .reset(reset), .rawButton(rawButton), .GO(GO),
    .btnLevel(btnLevel), .btnPress(btnPress),
    .outputState(outputState), .playing(playing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // ---------------- reference model ----------------
  // A level is accepted once the last DB synchronised samples all disagree with it.
  int            m_state;
  int            m_over;
  int            m_nwin;
  logic [NB-1:0] m_lvl;
  logic [NB-1:0] m_press;
  logic [DB-1:0] m_win [NB];
  logic [NB-1:0] m_sq [$];

  always @(posedge clk or posedge reset) begin : model
    logic [NB-1:0] s;
    logic [NB-1:0] p;
    logic          flip;
    int            ns;
    if (reset) begin
      m_state = 0; m_over = 0; m_nwin = 0; m_lvl = '0; m_press = '0;
      for (int i = 0; i < NB; i++) m_win[i] = '0;
      m_sq.delete();
      for (int i = 0; i < SY; i++) m_sq.push_back('0);
    end else begin
      p  = m_press;
      ns = m_state;
      case (m_state)
        0: if (p[0]) ns = 1;
        1: if (GO) ns = 3; else if (p[1]) ns = 2;
        2: if (p[0] || p[1]) ns = 1;
        3: begin
          m_over++;
          if (p[0]) ns = 0;
          else if (OH != 0 && m_over == OH) ns = 0;
        end
        default: ns = 0;
      endcase
      if (ns == 3 && m_state != 3) m_over = 0;
      m_state = ns;

      s = m_sq.pop_front();
      m_sq.push_back(rawButton);
      if (m_nwin < DB) m_nwin++;
      for (int i = 0; i < NB; i++) begin
        m_win[i]   = {m_win[i][DB-2:0], s[i]};
        flip       = (m_nwin == DB) && (m_win[i] == {DB{~m_lvl[i]}});
        m_press[i] = flip && !m_lvl[i];
        if (flip) m_lvl[i] = ~m_lvl[i];
      end
    end
  end

  always @(posedge clk) begin : scoreboard
    #2;
    if (!reset) begin
      chk("model_level",   btnLevel,    m_lvl);
      chk("model_press",   btnPress,    m_press);
      chk("model_state",   outputState, m_state);
      chk("model_playing", playing,     (m_state == 1));
    end
  end

  // Raise a button, wait for its press pulse, let the FSM take it, then release.
  task automatic press_btn(input int b);
    bit seen = 0;
    rawButton[b] = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (btnPress[b]) seen = 1;
    end
    chk("press_timeout", seen, 1);
    tick();
    rawButton[b] = 1'b0;
  endtask

  typedef struct {
    logic [NB-1:0] raw;
    logic          go;
    int            ncyc;
    int            exp_state;
    logic [NB-1:0] exp_lvl;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{4'b0001, 1'b0, 8, 1, 4'b0001};
    tbl[1] = '{4'b0000, 1'b0, 8, 1, 4'b0000};
    tbl[2] = '{4'b0010, 1'b0, 8, 2, 4'b0010};
    tbl[3] = '{4'b0000, 1'b0, 8, 2, 4'b0000};
    tbl[4] = '{4'b0001, 1'b0, 8, 1, 4'b0001};
    tbl[5] = '{4'b0000, 1'b1, 1, 3, 4'b0001};
    tbl[6] = '{4'b0000, 1'b0, 8, 0, 4'b0000};
    tbl[7] = '{4'b0100, 1'b0, 8, 0, 4'b0100};
    tbl[8] = '{4'b0000, 1'b0, 8, 0, 4'b0000};

    rawButton = '0; GO = 1'b0; reset = 1'b1;
    idle(3);
    chk("reset_state", outputState, 0);
    chk("reset_level", btnLevel, 0);
    chk("reset_press", btnPress, 0);
    chk("reset_playing", playing, 0);
    reset = 1'b0;
    idle(2);

    foreach (tbl[r]) begin
      rawButton = tbl[r].raw;
      GO        = tbl[r].go;
      idle(tbl[r].ncyc);
      chk($sformatf("vec%0d_state", r), outputState, tbl[r].exp_state);
      chk($sformatf("vec%0d_level", r), btnLevel, tbl[r].exp_lvl);
    end
    GO = 1'b0; rawButton = '0;
    idle(8);

    // Bouncing button never settles long enough to be accepted.
    for (int k = 0; k < 10; k++) begin
      rawButton[0] = ~rawButton[0];
      repeat (2) begin
        tick();
        chk("bounce_level", btnLevel[0], 0);
        chk("bounce_press", btnPress[0], 0);
        chk("bounce_state", outputState, 0);
      end
    end
    rawButton[0] = 1'b0;
    idle(8);
    chk("bounce_after", {btnLevel[0], outputState}, 0);

    // Press latency: pulse on the 6th edge, PLAY on the 7th.
    rawButton[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("lat_press_e%0d", k), btnPress[0], (k == 6));
      if (k == 7) begin
        chk("lat_state", outputState, 1);
        chk("lat_playing", playing, 1);
      end
    end
    rawButton[0] = 1'b0;
    idle(8);

    // Asynchronous reset between edges while in PLAY with a level held.
    rawButton[3] = 1'b1;
    idle(8);
    chk("pre_reset_level", btnLevel[3], 1);
    #1 reset = 1'b1;
    #1;
    chk("async_state", outputState, 0);
    chk("async_level", btnLevel, 0);
    chk("async_playing", playing, 0);
    rawButton = '0;
    #2 reset = 1'b0;
    idle(2);

    // Pause / resume with GO ignored while paused.
    press_btn(0);
    chk("p_play", outputState, 1);
    idle(8);
    press_btn(1);
    chk("p_pause", outputState, 2);
    idle(8);
    GO = 1'b1;
    repeat (3) begin
      tick();
      chk("p_go_ignored", outputState, 2);
    end
    GO = 1'b0;
    press_btn(1);
    chk("p_resume", outputState, 1);
    idle(8);

    // GO wins over a same-cycle pause press; then auto-return after OH cycles.
    begin
      bit seen = 0;
      rawButton[1] = 1'b1;
      for (int k = 0; k < 20 && !seen; k++) begin
        tick();
        if (btnPress[1]) seen = 1;
      end
      chk("go_pri_timeout", seen, 1);
    end
    GO = 1'b1;
    tick();
    GO = 1'b0;
    rawButton[1] = 1'b0;
    chk("go_pri_over", outputState, 3);
    for (int k = 1; k <= OH; k++) begin
      tick();
      chk($sformatf("hold_c%0d", k), outputState, (k < OH) ? 3 : 0);
    end
    idle(8);

    // Start press during OVER returns to IDLE before the hold expires.
    press_btn(0);
    chk("o_play", outputState, 1);
    idle(8);
    rawButton[0] = 1'b1;
    idle(2);
    GO = 1'b1;
    tick();
    GO = 1'b0;
    chk("o_over", outputState, 3);
    idle(3);
    chk("o_press", btnPress[0], 1);
    chk("o_still_over", outputState, 3);
    tick();
    chk("o_early_idle", outputState, 0);
    rawButton[0] = 1'b0;
    idle(8);

    // Illegal state recovers to IDLE.
    #1;
    force dut.r_state = 3'd6;
    m_state = 6;
    #1;
    chk("illegal_state", outputState, 6);
    chk("illegal_playing", playing, 0);
    release dut.r_state;
    tick();
    chk("illegal_recover", outputState, 0);

    // Auxiliary button has no effect on the FSM.
    press_btn(2);
    chk("aux_idle", outputState, 0);
    idle(8);
    press_btn(0);
    idle(8);
    press_btn(2);
    chk("aux_play", outputState, 1);
    idle(8);

    // Randomized traffic; the scoreboard compares every cycle.
    for (int n = 0; n < 3000; ) begin
      int len;
      len       = $urandom_range(1, 12);
      rawButton = NB'($urandom_range(0, 15));
      for (int j = 0; j < len; j++) begin
        GO = ($urandom_range(0, 15) == 0);
        if (n == 1500) reset = 1'b1;
        if (n == 1502) reset = 1'b0;
        tick();
        n++;
      end
    end
    reset = 1'b0;
    GO = 1'b0;
    rawButton = '0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
